// File: rtl/train_pkg.sv
// Shared definitions for the train arrival predictor: channel FSM encoding,
// derived-width helpers and the result clamp used on the divider output.
package train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TIMING = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DIV    = 2'd3
    } ch_state_e;

    // Width of a channel index; at least one bit so a single channel still has a port.
    function automatic int chw_of(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Width that holds elapsed * DIS_S2 exactly.
    function automatic int pw_of(input int tw, input int dis_s2);
        return tw + $clog2(dis_s2 + 1);
    endfunction

    // Quotient minus margin, clamped into [0, 2^tw-1].
    function automatic logic [63:0] clamp_pred(input logic [63:0] q, input int margin, input int tw);
        logic [63:0] max_v;
        logic [63:0] m;
        max_v = (64'd1 << tw) - 64'd1;
        m     = 64'(margin);
        if (q < m) return 64'd0;
        else if ((q - m) > max_v) return max_v;
        else return q - m;
    endfunction

    // High when clamp_pred had to limit the value at either end.
    function automatic logic is_sat(input logic [63:0] q, input int margin, input int tw);
        logic [63:0] max_v;
        logic [63:0] m;
        max_v = (64'd1 << tw) - 64'd1;
        m     = 64'(margin);
        return (q < m) || ((q - m) > max_v);
    endfunction

endpackage

// File: rtl/pred_divider.sv
// Restoring divider, one quotient bit per cycle. A start is taken only while
// idle; done pulses for one cycle once all PW bits are produced and the
// quotient then holds until the next start.
module pred_divider #(
    parameter int PW = 29
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [PW-1:0] dividend_i,
    input  logic [PW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [PW-1:0] quotient_o
);
    localparam int CW = $clog2(PW + 1);

    logic [PW-1:0] rem_q, rem_d;
    logic [PW-1:0] quo_q, quo_d;
    logic [PW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW:0]   shifted;
    logic [PW:0]   diff;

    // Next state: load on start, otherwise shift in one quotient bit per cycle.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[PW-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (busy_q) begin
            // Top bit of diff set means the trial subtraction borrowed: restore.
            if (diff[PW]) begin
                rem_d = shifted[PW-1:0];
                quo_d = {quo_q[PW-2:0], 1'b0};
            end else begin
                rem_d = diff[PW-1:0];
                quo_d = {quo_q[PW-2:0], 1'b1};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CW'(PW);
            busy_d = 1'b1;
        end
    end

    // Divider state register; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/arrival_predictor.sv
// Multi-channel train arrival predictor. Each channel times sensor-1 to
// sensor-2, then queues for the shared divider to turn the elapsed time into
// elapsed*DIS_S2/DIS_S1_S2 - MARGIN, clamped to TW bits.
module arrival_predictor
    import train_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int TW        = 19,
    parameter int TICK_DIV  = 50000,
    parameter int DIS_S1_S2 = 41,
    parameter int DIS_S2    = 666,
    parameter int MARGIN    = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         s1,
    input  logic [NUM_CH-1:0]         s2,
    output logic                      pred_valid,
    output logic [chw_of(NUM_CH)-1:0] pred_ch,
    output logic [TW-1:0]             pred_time,
    output logic                      pred_sat,
    output logic [NUM_CH-1:0]         timeout_err,
    output logic [NUM_CH-1:0]         busy
);
    localparam int CHW = chw_of(NUM_CH);
    localparam int PW  = pw_of(TW, DIS_S2);
    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] T_MAX = '1;

    logic [NUM_CH-1:0] s1_m_q, s1_s_q, s1_p_q, s2_m_q, s2_s_q, s2_p_q;
    logic [NUM_CH-1:0] s1_edge, s2_edge;
    logic [PSW-1:0]    presc_q, presc_d;
    logic              tick;

    ch_state_e [NUM_CH-1:0]       ch_state;    // all channel FSM states, one vector
    logic [NUM_CH-1:0][TW-1:0]    ch_elapsed;
    logic [NUM_CH-1:0]            req, in_div, grant, tmo_w;
    logic [TW-1:0]                sel_elapsed;
    logic [CHW-1:0]               sel_ch, div_ch_q;
    logic                         div_start, div_busy, div_done;
    logic [PW-1:0]                div_dividend, div_quo;

    logic                         pred_valid_q, pred_sat_q;
    logic [CHW-1:0]               pred_ch_q;
    logic [TW-1:0]                pred_time_q;
    logic [NUM_CH-1:0]            timeout_q;

    // Two-flop synchroniser plus a third flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_m_q <= '0; s1_s_q <= '0; s1_p_q <= '0;
            s2_m_q <= '0; s2_s_q <= '0; s2_p_q <= '0;
        end else begin
            s1_m_q <= s1;     s1_s_q <= s1_m_q; s1_p_q <= s1_s_q;
            s2_m_q <= s2;     s2_s_q <= s2_m_q; s2_p_q <= s2_s_q;
        end
    end

    assign s1_edge = s1_s_q & ~s1_p_q;
    assign s2_edge = s2_s_q & ~s2_p_q;

    // Shared prescaler: tick fires in the cycle the count wraps.
    assign tick    = (presc_q == PSW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PSW'(1);

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_e     state_q, state_d;
        logic [TW-1:0] elapsed_q, elapsed_d;
        logic          tmo_d;

        // Channel state and timer register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_IDLE;
                elapsed_q <= '0;
            end else begin
                state_q   <= state_d;
                elapsed_q <= elapsed_d;
            end
        end

        // Channel next state; the elapsed value is frozen from the s2 edge until the result.
        always_comb begin
            state_d   = state_q;
            elapsed_d = elapsed_q;
            case (state_q)
                ST_IDLE: begin
                    if (s1_edge[g]) begin
                        state_d   = ST_TIMING;
                        elapsed_d = '0;
                    end
                end
                ST_TIMING: begin
                    if (s2_edge[g])      state_d = ST_WAIT;
                    else if (s1_edge[g]) elapsed_d = '0;
                    else if (tick) begin
                        if (elapsed_q == T_MAX) state_d = ST_IDLE;
                        else                    elapsed_d = elapsed_q + TW'(1);
                    end
                end
                ST_WAIT: if (grant[g])  state_d = ST_DIV;
                ST_DIV:  if (div_done)  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Channel outputs: timeout when the timer would pass its maximum.
        always_comb begin
            tmo_d = (state_q == ST_TIMING) && !s2_edge[g] && !s1_edge[g] && tick &&
                    (elapsed_q == T_MAX);
        end

        assign ch_state[g]   = state_q;
        assign ch_elapsed[g] = elapsed_q;
        assign tmo_w[g]      = tmo_d;
    end

    // Decode per-channel status from the FSM state vector.
    always_comb begin
        req    = '0;
        in_div = '0;
        busy   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i]    = (ch_state[i] == ST_WAIT);
            in_div[i] = (ch_state[i] == ST_DIV);
            busy[i]   = (ch_state[i] != ST_IDLE);
        end
    end

    // Fixed-priority arbiter; waits until the previous owner has left DIV.
    always_comb begin
        grant       = '0;
        sel_elapsed = '0;
        sel_ch      = '0;
        if (!div_busy && !(|in_div)) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant       = '0;
                    grant[i]    = 1'b1;
                    sel_elapsed = ch_elapsed[i];
                    sel_ch      = CHW'(i);
                end
            end
        end
    end

    assign div_start    = |grant;
    assign div_dividend = PW'(sel_elapsed) * PW'(DIS_S2);

    pred_divider #(.PW(PW)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (PW'(DIS_S1_S2)),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Remember which channel owns the divider, then clamp and register its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_ch_q     <= '0;
            pred_valid_q <= 1'b0;
            pred_ch_q    <= '0;
            pred_time_q  <= '0;
            pred_sat_q   <= 1'b0;
            timeout_q    <= '0;
        end else begin
            if (div_start) div_ch_q <= sel_ch;
            pred_valid_q <= div_done;
            timeout_q    <= tmo_w;
            if (div_done) begin
                pred_ch_q   <= div_ch_q;
                pred_time_q <= TW'(clamp_pred(64'(div_quo), MARGIN, TW));
                pred_sat_q  <= is_sat(64'(div_quo), MARGIN, TW);
            end
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_ch     = pred_ch_q;
    assign pred_time   = pred_time_q;
    assign pred_sat    = pred_sat_q;
    assign timeout_err = timeout_q;

endmodule
